// File: rtl/demux_4x_nbit.sv
// Registered 1-to-4 demultiplexer: routes an N-bit word to one of four lanes,
// zeroing the idle lanes, with a one-hot lane-valid strobe.
module demux_4x_nbit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] y,
  input  logic [1:0]   sel,
  input  logic         in_valid,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic [N-1:0] d,
  output logic [3:0]   valid_out
);

  logic [N-1:0] a_q, b_q, c_q, d_q;
  logic [N-1:0] a_d, b_d, c_d, d_d;
  logic [3:0]   valid_q, valid_d;

  // Idle lanes load zero every cycle so no stale word ever lingers.
  always_comb begin
    a_d     = '0;
    b_d     = '0;
    c_d     = '0;
    d_d     = '0;
    valid_d = 4'b0000;
    if (in_valid) begin
      unique case (sel)
        2'b00: begin a_d = y; valid_d = 4'b0001; end
        2'b01: begin b_d = y; valid_d = 4'b0010; end
        2'b10: begin c_d = y; valid_d = 4'b0100; end
        2'b11: begin d_d = y; valid_d = 4'b1000; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 4'b0000;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      valid_q <= valid_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign d         = d_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_demux_4x_nbit.sv
// Scoreboard bench for demux_4x_nbit: N=8, N=16 and N=1 instances share one clock
// and reset; expectations are queued at drive time and popped after each edge.
module tb_demux_4x_nbit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  y8 = '0;
  logic [1:0]  sel8 = '0;
  logic        iv8 = 1'b0;
  logic [7:0]  a8, b8, c8, d8;
  logic [3:0]  v8;

  logic [15:0] y16 = '0;
  logic [1:0]  sel16 = '0;
  logic        iv16 = 1'b0;
  logic [15:0] a16, b16, c16, d16;
  logic [3:0]  v16;

  logic [0:0]  y1 = '0;
  logic [1:0]  sel1 = '0;
  logic        iv1 = 1'b0;
  logic [0:0]  a1, b1, c1, d1;
  logic [3:0]  v1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    int          inst;
    logic [15:0] ea, eb, ec, ed;
    logic [3:0]  ev;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  demux_4x_nbit #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .y(y8), .sel(sel8), .in_valid(iv8),
    .a(a8), .b(b8), .c(c8), .d(d8), .valid_out(v8)
  );

  demux_4x_nbit #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .y(y16), .sel(sel16), .in_valid(iv16),
    .a(a16), .b(b16), .c(c16), .d(d16), .valid_out(v16)
  );

  demux_4x_nbit #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .y(y1), .sel(sel1), .in_valid(iv1),
    .a(a1), .b(b1), .c(c1), .d(d1), .valid_out(v1)
  );

  // Reference behaviour: the selected lane carries y, everything else is zero.
  function automatic exp_t model(string tag, int inst, logic [15:0] yv,
                                 logic [1:0] s, logic v);
    exp_t e;
    e.tag  = tag;
    e.inst = inst;
    e.ea   = (v && s == 2'd0) ? yv : 16'h0;
    e.eb   = (v && s == 2'd1) ? yv : 16'h0;
    e.ec   = (v && s == 2'd2) ? yv : 16'h0;
    e.ed   = (v && s == 2'd3) ? yv : 16'h0;
    case (s)
      2'd0: e.ev = v ? 4'b0001 : 4'b0000;
      2'd1: e.ev = v ? 4'b0010 : 4'b0000;
      2'd2: e.ev = v ? 4'b0100 : 4'b0000;
      default: e.ev = v ? 4'b1000 : 4'b0000;
    endcase
    return e;
  endfunction

  task automatic compareField(string name, logic [15:0] obs, logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [15:0] oa, ob, oc, od;
    logic [3:0]  ov;
    if (sbq.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sbq.pop_front();
    case (e.inst)
      0: begin oa = {8'h0, a8}; ob = {8'h0, b8}; oc = {8'h0, c8}; od = {8'h0, d8}; ov = v8; end
      1: begin oa = a16; ob = b16; oc = c16; od = d16; ov = v16; end
      default: begin
        oa = {15'h0, a1}; ob = {15'h0, b1}; oc = {15'h0, c1}; od = {15'h0, d1}; ov = v1;
      end
    endcase
    compareField({e.tag, ".a"}, oa, e.ea);
    compareField({e.tag, ".b"}, ob, e.eb);
    compareField({e.tag, ".c"}, oc, e.ec);
    compareField({e.tag, ".d"}, od, e.ed);
    compareField({e.tag, ".valid"}, {12'h0, ov}, {12'h0, e.ev});
  endtask

  // Drives one instance at the falling edge, then checks just after the rising edge.
  task automatic applyStimulus(string tag, int inst, logic [15:0] yv,
                               logic [1:0] s, logic v);
    @(negedge clk);
    case (inst)
      0: begin y8 = yv[7:0]; sel8 = s; iv8 = v; end
      1: begin y16 = yv; sel16 = s; iv16 = v; end
      default: begin y1 = yv[0:0]; sel1 = s; iv1 = v; end
    endcase
    sbq.push_back(model(tag, inst, yv, s, v && rst_n));
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    sbq.push_back(model("reset_initial", 0, 16'h0, 2'd0, 1'b0));
    checkOutput();

    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("reset_hold%0d", i), 0, 16'd177, 2'b01, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    iv8 = 1'b0;

    for (int s = 0; s < 4; s++)
      applyStimulus($sformatf("sweep_sel%0d", s), 0, 16'd177, s[1:0], 1'b1);

    // Asynchronous clear between edges while lane d is holding data.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    sbq.push_back(model("async_reset", 0, 16'h0, 2'd0, 1'b0));
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("latency_a", 0, 16'd177, 2'b00, 1'b1);
    @(negedge clk);
    sel8 = 2'b10;
    #2;
    sbq.push_back(model("latency_hold", 0, 16'd177, 2'b00, 1'b1));
    checkOutput();
    sbq.push_back(model("latency_c", 0, 16'd177, 2'b10, 1'b1));
    @(posedge clk);
    #1;
    checkOutput();

    applyStimulus("data_0",   0, 16'd0,   2'b11, 1'b1);
    applyStimulus("data_1",   0, 16'd1,   2'b11, 1'b1);
    applyStimulus("data_128", 0, 16'd128, 2'b11, 1'b1);
    applyStimulus("data_255", 0, 16'd255, 2'b11, 1'b1);

    applyStimulus("gate_v1a", 0, 16'd177, 2'b01, 1'b1);
    applyStimulus("gate_v0",  0, 16'd177, 2'b01, 1'b0);
    applyStimulus("gate_v1b", 0, 16'd177, 2'b01, 1'b1);

    applyStimulus("n16_beef", 1, 16'hBEEF, 2'b10, 1'b1);
    for (int s = 0; s < 4; s++)
      applyStimulus($sformatf("n1_sel%0d", s), 2, 16'd1, s[1:0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/demux_4x_nbit.md
Name: demux_4x_nbit

Overview:
- Registered 1-to-4 demultiplexer for an N-bit data word.
- The 2-bit select `sel` routes input `y` to exactly one of four outputs: a, b, c or d. The three unselected outputs are driven to zero.
- Used as a generic fan-out stage ahead of per-lane consumers, for example the per-digit hex seven-segment decoders.
- Outputs are registered on the single system clock, with a one-hot lane-valid strobe alongside the data.

Parameters:
- N, 8, data width in bits of `y` and of each output lane (N >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- y  input  N  data word to be routed.
- sel  input  2  lane select: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
- in_valid  input  1  qualifies `y`/`sel`; tie to 1 for free-running demux.
- a  output  N  lane 0 data (registered).
- b  output  N  lane 1 data (registered).
- c  output  N  lane 2 data (registered).
- d  output  N  lane 3 data (registered).
- valid_out  output  4  one-hot lane strobe; bit0 = a, bit1 = b, bit2 = c, bit3 = d (registered).

Behaviour:
- Reset (rst_n = 0, asynchronous assert):
  - a, b, c, d = 0 and valid_out = 4'b0000 immediately, independent of clk.
  - Release is synchronous in effect: the first update occurs on the first rising clk edge with rst_n = 1.
- Latency is one clock: inputs sampled at edge k appear on the outputs after edge k.
- On each rising edge with in_valid = 1:
  - The selected lane register loads `y`; the other three lane registers load 0.
  - valid_out loads the one-hot code of `sel` (00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000).
- On each rising edge with in_valid = 0:
  - All four lane registers load 0 and valid_out loads 0000.
  - Idle lanes never show stale data.
- At most one lane is nonzero at any time. Exactly one valid_out bit is set when the prior cycle had in_valid = 1; none are set otherwise.
- Data is passed unmodified: no width change, no sign extension, and full N bits are preserved (e.g. N = 8, y = 255 -> lane = 255).
- A sel change between edges has no effect until the next edge. Back-to-back different selects move data lane to lane on consecutive cycles, with no bubble and no overlap.
- Reset asserted mid-stream clears all outputs at once. The in-flight word is discarded, not delayed.
- The output registers are the only state. There is no combinational path from inputs to outputs.
- sel = X/Z is outside the functional contract. Simulation may propagate X; no recovery logic is required.

Test Plan:
1. Reset: hold rst_n = 0 with y = 177, sel = 01, in_valid = 1 for 3 edges -> a = b = c = d = 0, valid_out = 0000 throughout. Then assert rst_n = 0 asynchronously between edges with outputs nonzero -> outputs clear before the next edge.
2. Select sweep (N = 8): y = 177, in_valid = 1, sel = 00, 01, 10, 11 on successive edges -> after each edge, in order:
   - (a, b, c, d) = (177, 0, 0, 0), valid_out = 0001
   - (0, 177, 0, 0), valid_out = 0010
   - (0, 0, 177, 0), valid_out = 0100
   - (0, 0, 0, 177), valid_out = 1000
3. Latency: change sel from 00 to 10 mid-cycle with y = 177 -> a stays 177 until the next rising edge, then a = 0, c = 177 on that edge. Nothing changes between edges.
4. Data integrity: sel = 11, y = 0, 1, 128, 255 on consecutive edges -> d follows 0, 1, 128, 255 one cycle later. a = b = c = 0 and valid_out = 1000 each cycle.
5. Valid gating: y = 177, sel = 01, in_valid pattern 1, 0, 1 -> b = 177, 0, 177 with valid_out = 0010, 0000, 0010.
6. Width parameter: N = 16, y = 16'hBEEF, sel = 10 -> c = 16'hBEEF, others 0. Repeat with N = 1, y = 1 on each sel to confirm single-bit lanes.
